host_link_arbiter: RTL
======================

Name: host_link_arbiter

Overview:
- Sits directly upstream of spi_bootloader, between the three host links (UART0 to the Crazyflie, UART1 to the pin header, I2C FSM) and the bootloader byte streams.
- Watches every link for the magic byte and locks the bootloader to the first link that sends it.
- Routes rx/tx bytes with valid/ready handshakes and discards traffic on the links that are not selected.
- Generates the bootloader reset pulse on lock, on break and on lock loss after an inactivity timeout.

Parameters:
- MAGIC_BYTE, 8'hbc, byte that locks a non-default channel.
- DEFAULT_CH, 2, channel routed while unlocked (I2C); it never needs the magic byte.
- TIMEOUT_CYCLES, 0, idle clk cycles before a locked channel is released; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ch_rx_valid  in  3  per-channel rx byte valid (bit0 UART0, bit1 UART1, bit2 I2C).
- ch_rx_data  in  24  per-channel rx byte; channel i occupies bits [8i+7:8i].
- ch_rx_ready  out  3  per-channel rx ready.
- ch_rx_break  in  3  per-channel break pulse.
- ch_tx_valid  out  3  per-channel tx valid.
- ch_tx_data  out  8  shared tx byte.
- ch_tx_ready  in  3  per-channel tx ready.
- ch_enabled  out  3  one-hot selected channel; drives the UART tx tristate enable.
- bl_in_valid / bl_in_data / bl_in_ready  out/out/in  1/8/1  byte stream into the bootloader.
- bl_out_valid / bl_out_data / bl_out_ready  in/in/out  1/8/1  byte stream out of the bootloader.
- bl_busy  in  1  bootloader busy; the timeout is suspended while it is high.
- bl_reset  out  1  one-cycle bootloader reset pulse.

Behaviour:
- Clock and reset: one clock domain (clk). reset is asynchronous and active-high.
  - On reset: state=UNLOCKED, sel=DEFAULT_CH, bl_reset=0, timeout counter=0.
  - ch_enabled=3'b100 while reset is asserted.
- State register: UNLOCKED or LOCKED, plus a 2-bit sel. ch_enabled = one-hot(sel).
- Routing is combinational from sel, with zero-cycle latency:
  - bl_in_valid = ch_rx_valid[sel]; bl_in_data = the sel byte of ch_rx_data.
  - ch_rx_ready[sel] = bl_in_ready.
  - ch_rx_ready[i != sel] = 1, so bytes on unselected channels are consumed and dropped.
  - ch_tx_valid[sel] = bl_out_valid; the other ch_tx_valid bits = 0.
  - ch_tx_data = bl_out_data; bl_out_ready = ch_tx_ready[sel].
- UNLOCKED:
  - A magic byte (ch_rx_valid[i] and byte==MAGIC_BYTE) on any channel i != DEFAULT_CH:
    - forces ch_rx_ready[i]=1 that cycle and swallows the byte; it is never forwarded;
    - next edge: sel<=i, state<=LOCKED, bl_reset<=1 for exactly one cycle.
  - Simultaneous magic bytes on several channels: the lowest index wins; the others are dropped.
  - A magic byte on DEFAULT_CH is forwarded as ordinary data.
  - ch_rx_break is ignored on all channels while unlocked.
- LOCKED:
  - ch_rx_break[sel] -> bl_reset pulse next cycle; the block stays LOCKED.
  - Breaks and magic bytes on other channels are ignored and their bytes dropped.
  - Magic bytes on sel are forwarded as data; no relock.
- Timeout (TIMEOUT_CYCLES>0, LOCKED only):
  - The counter clears on any rx or tx handshake on sel, or while bl_busy=1.
  - Otherwise it increments by 1 per cycle.
  - On reaching TIMEOUT_CYCLES-1: state<=UNLOCKED, sel<=DEFAULT_CH, bl_reset pulse, counter<=0.
  - Counter width is $clog2(TIMEOUT_CYCLES+1). The counter saturates and never wraps.
- bl_reset is registered. A lock and a break in the same cycle produce a single pulse.
- Reset asserted mid-transfer: the in-flight byte is abandoned and bl_reset stays 0. The bootloader has its own reset path.

Test Plan:
- After reset, drive 0x55 on I2C (ch2) -> bl_in_valid=1 with data 0x55. ch_enabled=3'b100. ch_tx_valid follows bl_out_valid on bit2 only.
- Drive 0xbc on UART1 -> the byte is not forwarded. Next cycle ch_enabled=3'b010 and bl_reset high for exactly 1 cycle. A following 0x12 on ch1 reaches bl_in_data.
- Drive 0xbc on ch0 and ch1 in the same cycle -> sel=0, a single bl_reset pulse, the ch1 byte is dropped (ch_rx_ready[1]=1).
- Locked on ch0, pulse ch_rx_break[1] and then ch_rx_break[0] -> no reset for ch1; bl_reset pulse one cycle after the ch0 break; still LOCKED.
- TIMEOUT_CYCLES=100, locked on ch0 with no traffic and bl_busy=0 -> UNLOCKED with sel=2 and a bl_reset pulse after exactly 100 cycles. Holding bl_busy=1 for 500 cycles -> no unlock.
- Locked on ch1, bl_in_ready=0 with ch1 valid held -> ch_rx_ready[1]=0 and the byte is held. Meanwhile ch0 sends 0xbc -> it is consumed and dropped; no relock.

Source files
------------

// File: rtl/host_link_arbiter.sv
// host_link_arbiter: locks the bootloader byte streams to one of three host
//   links (UART0, UART1, I2C) and pulses bl_reset on lock, break and timeout.
// Latency: rx/tx routing is combinational (zero cycles); bl_reset is registered
//   and appears one cycle after its cause.
// Backpressure: the selected link sees bl_in_ready / drives bl_out_ready;
//   unselected links are always ready, so their bytes are consumed and dropped.
//
// Ports:
//   clk, reset            single clock, asynchronous active-high reset
//   ch_rx_valid/data/ready per-link rx bytes (link i in ch_rx_data[8i+7:8i])
//   ch_rx_break           per-link break pulse
//   ch_tx_valid/ready     per-link tx handshake, ch_tx_data shared
//   ch_enabled            one-hot selected link (UART tx tristate enable)
//   bl_in_*               byte stream into the bootloader
//   bl_out_*              byte stream out of the bootloader
//   bl_busy               suspends the inactivity timeout
//   bl_reset              one-cycle bootloader reset pulse

module host_link_arbiter #(
  parameter logic [7:0] MAGIC_BYTE     = 8'hbc,
  parameter int         DEFAULT_CH     = 2,
  parameter int         TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  ch_rx_valid,
  input  logic [23:0] ch_rx_data,
  output logic [2:0]  ch_rx_ready,
  input  logic [2:0]  ch_rx_break,
  output logic [2:0]  ch_tx_valid,
  output logic [7:0]  ch_tx_data,
  input  logic [2:0]  ch_tx_ready,
  output logic [2:0]  ch_enabled,
  output logic        bl_in_valid,
  output logic [7:0]  bl_in_data,
  input  logic        bl_in_ready,
  input  logic        bl_out_valid,
  input  logic [7:0]  bl_out_data,
  output logic        bl_out_ready,
  input  logic        bl_busy,
  output logic        bl_reset
);

  localparam int NCH = 3;
  // Keep at least one counter bit so the timeout-disabled build still elaborates.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [1:0]    DEF_SEL  = 2'(DEFAULT_CH);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    sel_q, sel_d;
  logic          bl_reset_q, bl_reset_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [7:0]     rx_byte [NCH];
  logic [NCH-1:0] sel_oh;
  logic [NCH-1:0] magic_vec;
  logic           magic_any;
  logic [1:0]     magic_sel;
  logic           sel_hs;
  logic           brk_sel;

  for (genvar g = 0; g < NCH; g++) begin : g_rx_byte
    assign rx_byte[g] = ch_rx_data[8*g +: 8];
  end

  // One-hot of sel; an out-of-range sel selects nothing.
  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < NCH; i++) begin
      if (sel_q == 2'(i)) sel_oh[i] = 1'b1;
    end
  end

  // Magic byte on a non-default link while unlocked; the byte is swallowed,
  // never forwarded. Lowest index wins when several arrive together.
  always_comb begin
    magic_vec = '0;
    magic_any = 1'b0;
    magic_sel = DEF_SEL;
    for (int i = 0; i < NCH; i++) begin
      magic_vec[i] = (state_q == ST_UNLOCKED) && (i != DEFAULT_CH) &&
                     ch_rx_valid[i] && (rx_byte[i] == MAGIC_BYTE);
    end
    for (int i = NCH - 1; i >= 0; i--) begin
      if (magic_vec[i]) begin
        magic_any = 1'b1;
        magic_sel = 2'(i);
      end
    end
  end

  // Combinational routing from sel.
  always_comb begin
    bl_in_valid = |(ch_rx_valid & sel_oh);
    bl_in_data  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (sel_oh[i]) bl_in_data = rx_byte[i];
    end
    for (int i = 0; i < NCH; i++) begin
      ch_rx_ready[i] = sel_oh[i] ? (bl_in_ready | magic_vec[i]) : 1'b1;
    end
    ch_tx_valid  = bl_out_valid ? sel_oh : '0;
    ch_tx_data   = bl_out_data;
    bl_out_ready = |(ch_tx_ready & sel_oh);
  end

  assign sel_hs  = (bl_in_valid && bl_in_ready) || (bl_out_valid && bl_out_ready);
  assign brk_sel = |(ch_rx_break & sel_oh);

  // Next-state: lock, break, inactivity timeout. All reset causes in one
  // cycle merge into a single pulse because bl_reset_d is one bit.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    bl_reset_d = 1'b0;
    cnt_d      = cnt_q;
    case (state_q)
      ST_UNLOCKED: begin
        cnt_d = '0;
        if (magic_any) begin
          state_d    = ST_LOCKED;
          sel_d      = magic_sel;
          bl_reset_d = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (brk_sel) bl_reset_d = 1'b1;
        if (TIMEOUT_CYCLES > 0) begin
          if (sel_hs || bl_busy) begin
            cnt_d = '0;
          end else if (cnt_q >= CNT_LAST) begin
            state_d    = ST_UNLOCKED;
            sel_d      = DEF_SEL;
            bl_reset_d = 1'b1;
            cnt_d      = '0;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = ST_UNLOCKED;
        sel_d   = DEF_SEL;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_UNLOCKED;
      sel_q      <= DEF_SEL;
      bl_reset_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      bl_reset_q <= bl_reset_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ch_enabled = sel_oh;
  assign bl_reset   = bl_reset_q;

endmodule
